// File: rtl/shift_sequencer.sv
// Multi-cycle controller that turns a single-position shifter into an N-position
// shift/rotate unit by feeding each result back onto A_bus once per clock.
module shift_sequencer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CNT_W-1:0] count,
   input  logic [15:0]      din,
   input  logic             cf_init,
   input  logic [15:0]      shf_result,
   input  logic             shf_cf,
   output logic             Rin,
   output logic             Lin,
   output logic             Ain,
   output logic             Bin,
   output logic             Cin,
   output logic             Din,
   output logic             Ein,
   output logic             SHS,
   output logic [15:0]      A_bus,
   output logic             busy,
   output logic             done,
   output logic [15:0]      result,
   output logic             cf
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic             cf_q, cf_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic in_shift, in_done, decode_c;

   always_comb begin
      // NOTE: every _d starts as its _q so no path through the case can infer a latch.
      state_d = state_q;
      acc_d   = acc_q;
      cf_d    = cf_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d   = din;
               cf_d    = cf_init;
               op_d    = op;
               cnt_d   = count;
               state_d = (count != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            acc_d = shf_result;
            cf_d  = shf_cf;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cf_q    <= 1'b0;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cf_q    <= cf_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_shift = (state_q == ST_SHIFT);
   assign in_done  = (state_q == ST_DONE);

   // Carry is offered to the shifter only for the left modes that can consume it.
   assign decode_c = (op_q == 3'b000) || (op_q == 3'b100) || (op_q == 3'b110);

   assign Rin = in_shift &  op_q[0];
   assign Lin = in_shift & ~op_q[0];
   assign Ain = in_shift & (op_q[2:1] == 2'b01);
   assign Bin = in_shift & (op_q == 3'b000);
   assign Din = in_shift & (op_q == 3'b001);
   assign Ein = in_shift & (op_q[2:1] == 2'b11);
   assign Cin = in_shift & decode_c & cf_q;
   assign SHS = in_shift;

   assign A_bus  = acc_q;
   assign result = acc_q;
   assign cf     = cf_q;
   assign busy   = in_shift | in_done;
   assign done   = in_done;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that sits around the single-bit `shifter_module`, upstream on its control lines and downstream on its result. It accepts a shift opcode, a 16-bit operand and a repeat count, then drives the shifter once per clock. Each cycle it feeds the previous result back onto `A_bus` and captures `shifter_result_bus` and `Cf`, which turns the one-position shifter into an N-position shift/rotate unit for the datapath.

## Interface
Parameters:
- `CNT_W`, default 4: width of the repeat count; counts range 0..2^CNT_W-1.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request pulse. Sampled only in IDLE.
- `op`  in  3: mode code. 000 ROL, 001 ROR, 010 ASL, 011 ASR, 100 LSL, 101 LSR, 110 RLC, 111 RRC.
- `count`  in  CNT_W: number of single-bit shifts.
- `din`  in  16: initial operand.
- `cf_init`  in  1: initial carry, used by RLC/RRC.
- `shf_result`  in  16: from shifter `shifter_result_bus`.
- `shf_cf`  in  1: from shifter `Cf`.
- `Rin`, `Lin`, `Ain`, `Bin`, `Cin`, `Din`, `Ein`, `SHS`  out  1 each: shifter controls.
- `A_bus`  out  16: shifter operand.
- `busy`  out  1: high in SHIFT and DONE.
- `done`  out  1: one-cycle completion pulse.
- `result`  out  16: accumulated value.
- `cf`  out  1: carry register.

## Operation
- Registers:
  - `acc[15:0]`, `cf_reg`, `op_reg[2:0]`, `cnt[CNT_W-1:0]`.
  - State: IDLE, SHIFT, DONE.
- IDLE with `start`=1 loads `acc`←`din`, `cf_reg`←`cf_init`, `op_reg`←`op`, `cnt`←`count`.
  - Next state is SHIFT if `count`≠0, otherwise DONE.
- SHIFT, every cycle: `acc`←`shf_result`, `cf_reg`←`shf_cf`, `cnt`←`cnt`−1.
  - When `cnt`=1 the next state is DONE.
- DONE: `done`=1, then next state IDLE.
- `start` is ignored in SHIFT and DONE. No queuing.
- Control decode, combinational from `op_reg`, asserted only in SHIFT. All lines are 0 in IDLE and DONE.
  - `Rin`=op_reg[0]; `Lin`=~op_reg[0].
  - `Ain`=1 for 010 and 011.
  - `Bin`=1 for 000.
  - `Din`=1 for 001.
  - `Ein`=1 for 110 and 111.
  - `Cin` = decodeC & `cf_reg`, where decodeC=1 for 000, 100 and 110.
  - `SHS`=1.
- `A_bus`=`acc` at all times.
- `result`=`acc` and `cf`=`cf_reg` at all times. Both hold after DONE until the next accepted `start`.
- Carry semantics: after each step `cf_reg` holds the bit shifted out of that step. After N steps `cf` is the last bit shifted out. For count 0, `cf` equals `cf_init`.

## Timing
- Reset values: state IDLE; `acc`=0, `cf_reg`=0, `op_reg`=0, `cnt`=0. All outputs 0: `busy`, `done`, every control line, `A_bus`, `result`, `cf`.
- Reset has priority over every other event.
  - Reset asserted mid-SHIFT or in DONE aborts the operation: IDLE and all-zero outputs the cycle after the reset edge.
  - No `done` is produced for the aborted operation.
- Latency for `start` accepted at edge 0:
  - SHIFT occupies cycles 1..N.
  - DONE (`done`=1) is cycle N+1.
  - IDLE is cycle N+2, where a new `start` is accepted.
- Count 0: DONE in cycle 1 with `result`=`din`.
- `shf_result` and `shf_cf` are combinational from the controls and `A_bus`. They are sampled at the end of every SHIFT cycle and ignored otherwise.
- Maximum count 2^CNT_W−1. The counter never wraps.

## Test plan
- LSL, `din`=0x00F1, `count`=4, `cf_init`=1 → `done` in cycle 5, `result`=0x0F10, `cf`=0. `Cin`=1 in each SHIFT cycle only while `cf_reg`=1; the bench checks this per cycle.
- ROR, `din`=0x0001, `count`=1 → cycle 1 shows `Rin`=1, `Din`=1, `SHS`=1; `done` in cycle 2, `result`=0x8000, `cf`=1.
- ASR, `din`=0x8010, `count`=3 → `result`=0xF002, `cf`=0, `busy` high for cycles 1..4.
- RRC, `din`=0x0001, `cf_init`=0, `count`=2 → after step 1 `acc`=0x0000 with `cf`=1; final `result`=0x8000, `cf`=0.
- `count`=0 with `din`=0xABCD → `done` in cycle 1, `result`=0xABCD, no control line ever asserted. A `start` pulsed during the SHIFT of a count=5 operation is ignored: exactly one `done`, in cycle 6.
- `reset` asserted in cycle 2 of a count=8 ROL → next cycle IDLE, `result`=0, `busy`=0, no `done`. A following `start` with count=1 completes normally.
